// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multiply/divide sequencer.
//   - R-type funct codes handled by (or related to) the HI/LO unit
//   - sequencer FSM state encoding
//   - LO value written by a divide whose divisor is zero
package muldiv_pkg;

    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam logic [31:0] DIVZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one-bit-per-cycle multiply/divide datapath on unsigned magnitudes.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       latch operands, clear remainder, counter <= WIDTH-1
//   load_div   operation type captured on load (1 = divide)
//   step       advance one iteration, counter decrements
//   op_a       multiplicand / dividend magnitude
//   op_b       multiplier / divisor magnitude
//   acc_o      multiply: 2*WIDTH product; divide: quotient in [WIDTH-1:0]
//   rem_o      divide remainder (WIDTH+1 bits)
//   done_o     counter has reached zero (current step is the last)
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               load_div,
    input  logic               step,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [WIDTH:0]     rem_o,
    output logic               done_o
);

    logic               div_q, div_d;
    logic [WIDTH-1:0]   opr_q, opr_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH+1:0]   trial;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc LSB) is set, then shift the whole accumulator right.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opr_q} : '0);
        // Divide: bring the next dividend bit into the partial remainder and
        // trial-subtract; the extra top bit of trial is the borrow.
        shifted = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, opr_q};

        div_d = div_q;
        opr_d = opr_q;
        acc_d = acc_q;
        rem_d = rem_q;
        cnt_d = cnt_q;

        if (load) begin
            div_d = load_div;
            opr_d = load_div ? op_b : op_a;
            acc_d = {{WIDTH{1'b0}}, (load_div ? op_a : op_b)};
            rem_d = '0;
            cnt_d = CW'(WIDTH - 1);
        end else if (step) begin
            cnt_d = cnt_q - CW'(1);
            if (div_q) begin
                if (!trial[WIDTH+1]) begin
                    rem_d              = trial[WIDTH:0];
                    acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d              = shifted;
                    acc_d[WIDTH-1:0]   = {acc_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= 1'b0;
            opr_q <= '0;
            acc_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            opr_q <= opr_d;
            acc_q <= acc_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
        end
    end

    assign acc_o  = acc_q;
    assign rem_o  = rem_q;
    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: MULT/MULTU/DIV/DIVU sequencer and HI/LO register owner.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, funct      EX-stage request and its R-type funct
//   rs_data, rt_data  operands (rs also the MTHI/MTLO source)
//   flush             cancel in-flight operation / drop a same-cycle start
//   busy              registered, high while an operation is in flight
//   hi_o, lo_o        HI and LO registers
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             div_q, div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rs_q, neg_rs_d;
    logic             divz_q, divz_d;
    logic [WIDTH-1:0] rs_q, rs_d;

    logic             is_md, is_signed, is_div;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             load, step, done;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH:0]     rem_fix;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_div (is_div),
        .step     (step),
        .op_a     (a_mag),
        .op_b     (b_mag),
        .acc_o    (acc),
        .rem_o    (rem),
        .done_o   (done)
    );

    always_comb begin
        is_md     = (funct == FN_MULT) || (funct == FN_MULTU) ||
                    (funct == FN_DIV)  || (funct == FN_DIVU);
        is_signed = (funct == FN_MULT) || (funct == FN_DIV);
        is_div    = (funct == FN_DIV)  || (funct == FN_DIVU);
        a_mag     = (is_signed && rs_data[WIDTH-1]) ? -rs_data : rs_data;
        b_mag     = (is_signed && rt_data[WIDTH-1]) ? -rt_data : rt_data;

        prod_fix  = neg_res_q ? -acc : acc;
        quo_fix   = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rs_q ? -rem : rem;

        state_d   = state_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_d     = div_q;
        neg_res_d = neg_res_q;
        neg_rs_d  = neg_rs_q;
        divz_d    = divz_q;
        rs_d      = rs_q;
        load      = 1'b0;
        step      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (is_md) begin
                        load      = 1'b1;
                        state_d   = RUN;
                        busy_d    = 1'b1;
                        div_d     = is_div;
                        neg_res_d = is_signed && (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                        neg_rs_d  = is_signed && rs_data[WIDTH-1];
                        divz_d    = is_div && (rt_data == '0);
                        rs_d      = rs_data;
                    end else if (funct == FN_MTHI) begin
                        hi_d = rs_data;
                    end else if (funct == FN_MTLO) begin
                        lo_d = rs_data;
                    end
                end
            end
            RUN: begin
                step = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    if (!div_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else if (divz_q) begin
                        // Divide by zero reports the raw dividend, not its magnitude.
                        hi_d = rs_q;
                        lo_d = DIVZ_LO;
                    end else begin
                        hi_d = WIDTH'(rem_fix);
                        lo_d = quo_fix;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            div_q     <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rs_q  <= 1'b0;
            divz_q    <= 1'b0;
            rs_q      <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            div_q     <= div_d;
            neg_res_q <= neg_res_d;
            neg_rs_q  <= neg_rs_d;
            divz_q    <= divz_d;
            rs_q      <= rs_d;
        end
    end

    assign busy = busy_q;
    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed-vector bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        flush = 1'b0;
    logic        busy;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .funct   (funct),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .flush   (flush),
        .busy    (busy),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    // Present a request for exactly one rising edge; returns at the
    // falling edge after that edge (T0).
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start   = 1'b1;
        funct   = f;
        rs_data = a;
        rt_data = b;
        @(negedge clk);
        start   = 1'b0;
        funct   = '0;
    endtask

    // Counts falling edges with busy high, bounded so a stuck busy cannot hang.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_vec++; if (hi_o !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h want 00000000", hi_o); end
        n_vec++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h want 00000000", lo_o); end
    endtask

    task automatic test_mul();
        int cyc;
        issue(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL multu_busy_len: got %0d want 33", cyc); end
        n_vec++; if (hi_o !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", hi_o); end
        n_vec++; if (lo_o !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", lo_o); end

        issue(F_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(cyc);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL mult_busy_len: got %0d want 33", cyc); end
        n_vec++; if (hi_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi_o); end
        n_vec++; if (lo_o !== 32'hFFFF_FFEB) begin n_err++; $display("FAIL mult_lo: got %h want ffffffeb", lo_o); end
    endtask

    task automatic test_div();
        int cyc;
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        n_vec++; if (hi_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_neg_hi: got %h want ffffffff", hi_o); end
        n_vec++; if (lo_o !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg_lo: got %h want fffffffd", lo_o); end

        issue(F_DIVU, 32'd100, 32'd7);
        wait_done(cyc);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL divu_busy_len: got %0d want 33", cyc); end
        n_vec++; if (hi_o !== 32'd2) begin n_err++; $display("FAIL divu_hi: got %h want 00000002", hi_o); end
        n_vec++; if (lo_o !== 32'd14) begin n_err++; $display("FAIL divu_lo: got %h want 0000000e", lo_o); end

        issue(F_DIVU, 32'h0000_1234, 32'h0);
        wait_done(cyc);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL divz_busy_len: got %0d want 33", cyc); end
        n_vec++; if (hi_o !== 32'h0000_1234) begin n_err++; $display("FAIL divuz_hi: got %h want 00001234", hi_o); end
        n_vec++; if (lo_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divuz_lo: got %h want ffffffff", lo_o); end

        issue(F_DIV, 32'hFFFF_EDCC, 32'h0);
        wait_done(cyc);
        n_vec++; if (hi_o !== 32'hFFFF_EDCC) begin n_err++; $display("FAIL divz_neg_hi: got %h want ffffedcc", hi_o); end
        n_vec++; if (lo_o !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divz_neg_lo: got %h want ffffffff", lo_o); end

        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        n_vec++; if (hi_o !== 32'h0) begin n_err++; $display("FAIL div_ovf_hi: got %h want 00000000", hi_o); end
        n_vec++; if (lo_o !== 32'h8000_0000) begin n_err++; $display("FAIL div_ovf_lo: got %h want 80000000", lo_o); end
    endtask

    task automatic test_mt_busy();
        int cyc;
        issue(F_MTHI, 32'h1234_5678, 32'h0);
        n_vec++; if (hi_o !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h want 12345678", hi_o); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mthi_busy: got %b want 0", busy); end

        issue(F_MULTU, 32'h0001_0000, 32'h0003_0000);
        repeat (4) @(negedge clk);
        start   = 1'b1;
        funct   = F_MTLO;
        rs_data = 32'hAAAA_AAAA;
        @(negedge clk);
        start   = 1'b0;
        funct   = '0;
        wait_done(cyc);
        n_vec++; if (cyc + 5 !== 33) begin n_err++; $display("FAIL busy_start_len: got %0d want 33", cyc + 5); end
        n_vec++; if (hi_o !== 32'h0000_0003) begin n_err++; $display("FAIL busy_start_hi: got %h want 00000003", hi_o); end
        n_vec++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL busy_start_lo: got %h want 00000000", lo_o); end
    endtask

    task automatic test_flush();
        int cyc;
        // start with flush in IDLE: both a mul/div and an MTHI are dropped
        @(negedge clk);
        start = 1'b1; funct = F_MULT; rs_data = 32'd5; rt_data = 32'd5; flush = 1'b1;
        @(negedge clk);
        funct = F_MTHI; rs_data = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; funct = '0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_start_busy: got %b want 0", busy); end
        n_vec++; if (hi_o !== 32'h0000_0003) begin n_err++; $display("FAIL flush_start_hi: got %h want 00000003", hi_o); end

        issue(F_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_run_busy: got %b want 0", busy); end
        n_vec++; if (hi_o !== 32'h0000_0003) begin n_err++; $display("FAIL flush_run_hi: got %h want 00000003", hi_o); end
        n_vec++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL flush_run_lo: got %h want 00000000", lo_o); end

        issue(F_MULTU, 32'h0001_0001, 32'h0007_0000);
        wait_done(cyc);
        n_vec++; if (cyc !== 33) begin n_err++; $display("FAIL after_flush_len: got %0d want 33", cyc); end
        n_vec++; if (hi_o !== 32'h0000_0007) begin n_err++; $display("FAIL after_flush_hi: got %h want 00000007", hi_o); end
        n_vec++; if (lo_o !== 32'h0007_0000) begin n_err++; $display("FAIL after_flush_lo: got %h want 00070000", lo_o); end
    endtask

    task automatic test_rst_mid();
        issue(F_MULT, 32'd5, 32'd6);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        n_vec++; if (hi_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_hi: got %h want 00000000", hi_o); end
        n_vec++; if (lo_o !== 32'h0) begin n_err++; $display("FAIL rst_mid_lo: got %h want 00000000", lo_o); end
        repeat (3) @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_mid_stays_idle: got %b want 0", busy); end
    endtask

    task automatic test_flush_fix();
        issue(F_MTHI, 32'h0000_CAFE, 32'h0);
        issue(F_MTLO, 32'h0000_BEEF, 32'h0);
        issue(F_MULTU, 32'd2, 32'd3);
        repeat (32) @(negedge clk);
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL fix_cycle_busy: got %b want 1", busy); end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_fix_busy: got %b want 0", busy); end
        n_vec++; if (hi_o !== 32'h0000_CAFE) begin n_err++; $display("FAIL flush_fix_hi: got %h want 0000cafe", hi_o); end
        n_vec++; if (lo_o !== 32'h0000_BEEF) begin n_err++; $display("FAIL flush_fix_lo: got %h want 0000beef", lo_o); end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_mt_busy();
        test_flush();
        test_rst_mid();
        test_flush_fix();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
